// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: captures a multi-hot request vector and streams out one set index per handshake.
// Define PRIORITY_MSB_FIRST_EN to serve the highest set index first instead of the lowest.
module priority_scan_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [IDX_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             last,
  output logic             none
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             none_q, none_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [N-1:0]     sel_mask;
  logic             one_left;

  // Index selection is the only logic the scan-order macro touches.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
`ifdef PRIORITY_MSB_FIRST_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (pending_q[k] && !sel_found) begin
        sel_idx   = IDX_W'(k);
        sel_found = 1'b1;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      if (pending_q[k] && !sel_found) begin
        sel_idx   = IDX_W'(k);
        sel_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    sel_mask = N'(1) << sel_idx;
    one_left = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  end

  assign y_valid = (state_q == SCAN);
  assign y       = y_valid ? sel_idx : '0;
  assign last    = y_valid && one_left;
  assign none    = none_q;
  assign i_ready = rst_n && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i != '0) begin
            pending_d = i;
            state_d   = SCAN;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (y_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (one_left) begin
            pending_d = '0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench for priority_scan_encoder: directed cases on an 8-bit instance, random sweeps on 8- and 13-bit instances.
// Honors PRIORITY_MSB_FIRST_EN when the design is built with it.
module tb_priority_scan_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  i8;
  logic        iv8, ir8, yv8, yr8, last8, none8;
  logic [2:0]  y8;
  logic [12:0] i13;
  logic        iv13, ir13, yv13, yr13, last13, none13;
  logic [3:0]  y13;

  priority_scan_encoder #(.N(8), .IDX_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .i_valid(iv8), .i_ready(ir8),
    .y(y8), .y_valid(yv8), .y_ready(yr8), .last(last8), .none(none8)
  );

  priority_scan_encoder #(.N(13), .IDX_W(4)) dut13 (
    .clk(clk), .rst_n(rst_n), .i(i13), .i_valid(iv13), .i_ready(ir13),
    .y(y13), .y_valid(yv13), .y_ready(yr13), .last(last13), .none(none13)
  );

  typedef struct {
    int idx;
    bit last;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];
  bit   exp_none8  = 1'b0;
  bit   exp_none13 = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic valid, input logic ready);
    i8  = v;
    iv8 = valid;
    yr8 = ready;
  endtask

  // Reference: list the set bit positions in service order; the final one carries last.
  task automatic model_push(input int which, input logic [63:0] v, input int n);
    int   idxs[$];
    exp_t e;
    for (int b = 0; b < n; b++) begin
      if (v[b]) begin
`ifdef PRIORITY_MSB_FIRST_EN
        idxs.push_front(b);
`else
        idxs.push_back(b);
`endif
      end
    end
    for (int j = 0; j < idxs.size(); j++) begin
      e.idx  = idxs[j];
      e.last = (j == idxs.size() - 1);
      if (which == 8) q8.push_back(e);
      else q13.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      exp_none8 = 1'b0;
    end else begin
      if (yv8) begin
        if (q8.size() == 0) begin
          checkOutput("dut8 unexpected y_valid", 64'(yv8), 64'(0));
        end else begin
          checkOutput("dut8 y", 64'(y8), 64'(q8[0].idx));
          checkOutput("dut8 last", 64'(last8), 64'(q8[0].last));
          if (yr8) void'(q8.pop_front());
        end
      end
      if (none8 || exp_none8) checkOutput("dut8 none", 64'(none8), 64'(exp_none8));
      exp_none8 = iv8 && ir8 && (i8 == '0);
      if (iv8 && ir8 && (i8 != '0)) model_push(8, 64'(i8), 8);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q13.delete();
      exp_none13 = 1'b0;
    end else begin
      if (yv13) begin
        if (q13.size() == 0) begin
          checkOutput("dut13 unexpected y_valid", 64'(yv13), 64'(0));
        end else begin
          checkOutput("dut13 y", 64'(y13), 64'(q13[0].idx));
          checkOutput("dut13 last", 64'(last13), 64'(q13[0].last));
          if (yr13) void'(q13.pop_front());
        end
      end
      if (none13 || exp_none13) checkOutput("dut13 none", 64'(none13), 64'(exp_none13));
      exp_none13 = iv13 && ir13 && (i13 == '0);
      if (iv13 && ir13 && (i13 != '0)) model_push(13, 64'(i13), 13);
    end
  end

  task automatic random_run8();
    bit acc;
    int budget;
    for (int n = 0; n < 200; n++) begin
      i8     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      iv8    = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        acc = ir8;
        yr8 = 1'($urandom_range(0, 1));
        tick();
        budget++;
      end
      iv8 = 1'b0;
      checkOutput("dut8 vector accepted", 64'(acc), 64'(1));
      if (!acc) break;
      if ($urandom_range(0, 3) == 0) begin
        yr8 = 1'($urandom_range(0, 1));
        tick();
      end
    end
  endtask

  task automatic random_run13();
    bit acc;
    int budget;
    for (int n = 0; n < 200; n++) begin
      i13    = ($urandom_range(0, 7) == 0) ? 13'h0 : 13'($urandom);
      iv13   = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        acc  = ir13;
        yr13 = 1'($urandom_range(0, 1));
        tick();
        budget++;
      end
      iv13 = 1'b0;
      checkOutput("dut13 vector accepted", 64'(acc), 64'(1));
      if (!acc) break;
      if ($urandom_range(0, 3) == 0) begin
        yr13 = 1'($urandom_range(0, 1));
        tick();
      end
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int free_seq[4];
    int bp_first;
    int bp_second;
`ifdef PRIORITY_MSB_FIRST_EN
    free_seq  = '{7, 5, 2, 1};
    bp_first  = 7;
    bp_second = 0;
`else
    free_seq  = '{1, 2, 5, 7};
    bp_first  = 0;
    bp_second = 7;
`endif
    rst_n = 1'b0;
    i8 = '0; iv8 = 1'b0; yr8 = 1'b0;
    i13 = '0; iv13 = 1'b0; yr13 = 1'b0;
    tick();
    tick();
    checkOutput("reset y", 64'(y8), 64'(0));
    checkOutput("reset y_valid", 64'(yv8), 64'(0));
    checkOutput("reset last", 64'(last8), 64'(0));
    checkOutput("reset none", 64'(none8), 64'(0));
    checkOutput("reset i_ready", 64'(ir8), 64'(0));
    rst_n = 1'b1;
    tick();
    checkOutput("i_ready after release", 64'(ir8), 64'(1));

    applyStimulus(8'b1010_0110, 1'b1, 1'b1);
    tick();
    iv8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("free y_valid", 64'(yv8), 64'(1));
      checkOutput("free y", 64'(y8), 64'(free_seq[c]));
      checkOutput("free last", 64'(last8), 64'(c == 3));
      checkOutput("free i_ready busy", 64'(ir8), 64'(0));
      tick();
    end
    checkOutput("free i_ready fifth cycle", 64'(ir8), 64'(1));
    checkOutput("free y_valid done", 64'(yv8), 64'(0));

    applyStimulus(8'b1000_0001, 1'b1, 1'b0);
    tick();
    iv8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall y held", 64'(y8), 64'(bp_first));
      checkOutput("stall y_valid", 64'(yv8), 64'(1));
      checkOutput("stall last", 64'(last8), 64'(0));
      if (c == 2) yr8 = 1'b1;
      tick();
    end
    checkOutput("stall second y", 64'(y8), 64'(bp_second));
    checkOutput("stall second last", 64'(last8), 64'(1));
    tick();
    checkOutput("stall back to idle", 64'(ir8), 64'(1));
    checkOutput("stall y_valid idle", 64'(yv8), 64'(0));

    applyStimulus(8'h00, 1'b1, 1'b1);
    tick();
    iv8 = 1'b0;
    checkOutput("zero none pulse", 64'(none8), 64'(1));
    checkOutput("zero i_ready", 64'(ir8), 64'(1));
    checkOutput("zero y_valid", 64'(yv8), 64'(0));
    tick();
    checkOutput("zero none cleared", 64'(none8), 64'(0));
    checkOutput("zero i_ready after", 64'(ir8), 64'(1));

    applyStimulus(8'b0001_0000, 1'b1, 1'b1);
    tick();
    iv8 = 1'b0;
    checkOutput("single y", 64'(y8), 64'(4));
    checkOutput("single last", 64'(last8), 64'(1));
    checkOutput("single y_valid", 64'(yv8), 64'(1));
    tick();
    checkOutput("single y_valid done", 64'(yv8), 64'(0));
    checkOutput("single i_ready", 64'(ir8), 64'(1));

    applyStimulus(8'hFF, 1'b1, 1'b1);
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midscan reset y_valid", 64'(yv8), 64'(0));
    checkOutput("midscan reset y", 64'(y8), 64'(0));
    checkOutput("midscan reset last", 64'(last8), 64'(0));
    checkOutput("midscan reset i_ready", 64'(ir8), 64'(0));
    checkOutput("midscan reset none", 64'(none8), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("post reset no index", 64'(yv8), 64'(0));
    end
    checkOutput("post reset i_ready", 64'(ir8), 64'(1));

    fork
      random_run8();
      random_run13();
    join

    yr8  = 1'b1;
    yr13 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (q8.size() == 0 && q13.size() == 0 && ir8 && ir13) break;
      tick();
    end
    tick();
    checkOutput("dut8 scoreboard drained", 64'(q8.size()), 64'(0));
    checkOutput("dut13 scoreboard drained", 64'(q13.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
